// File: rtl/lzc_pkg.sv
// lzc_pkg: shared constants and helpers for the leading-zero normaliser
package lzc_pkg;
  localparam int NIB_W = 4;
  function automatic int clog2_w(input int width);
    for (int r = 0; r < 32; r++)
      if ((1 << r) >= width + 1) return r;
    return 32;
  endfunction
  function automatic logic [2:0] nib_count(input logic [3:0] n);
    return n[3] ? 3'b000 : n[2] ? 3'b001 : n[1] ? 3'b010 : n[0] ? 3'b011 : 3'b100;
  endfunction
endpackage

// File: rtl/lzc_nibble.sv
// lzc_nibble: leading-zero count and zero flag of one 4-bit nibble
module lzc_nibble
  import lzc_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [1:0]       count,
  output logic             zero
);
  assign {zero, count} = nib_count(nib);
endmodule

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage leading-zero counter and left normaliser with valid/ready
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter  int WIDTH = 24,
  parameter  int TAG_W = 10,
  localparam int CW    = clog2_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);
  localparam int N = WIDTH / NIB_W;
  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
  logic [N-1:0][1:0]  s1_cnt_q, s1_cnt_d, nib_cnt;
  logic [N-1:0]       s1_zero_q, s1_zero_d, nib_zero;
  logic               out_valid_q, out_valid_d;
  logic [CW-1:0]      out_count_q, out_count_d, sel_cnt;
  logic               out_zero_q, out_zero_d;
  logic [WIDTH-1:0]   out_norm_q, out_norm_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               s1_adv, s2_adv, in_acc, s2_ld;
  // nibble 0 is the most significant nibble
  for (genvar g = 0; g < N; g++) begin : g_nib
    lzc_nibble u_nib (
      .nib  (in_data[WIDTH-1-NIB_W*g -: NIB_W]),
      .count(nib_cnt[g]),
      .zero (nib_zero[g])
    );
  end
  assign s2_adv   = ~out_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  assign in_acc   = in_valid & s1_adv;
  assign s2_ld    = s2_adv & s1_valid_q;
  always_comb begin
    sel_cnt = CW'(WIDTH);
    for (int i = N - 1; i >= 0; i--)
      if (!s1_zero_q[i]) sel_cnt = CW'(NIB_W * i) + CW'(s1_cnt_q[i]);
    s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
    s1_data_d   = in_acc ? in_data : s1_data_q;
    s1_tag_d    = in_acc ? in_tag : s1_tag_q;
    s1_cnt_d    = in_acc ? nib_cnt : s1_cnt_q;
    s1_zero_d   = in_acc ? nib_zero : s1_zero_q;
    out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
    out_count_d = s2_ld ? sel_cnt : out_count_q;
    out_zero_d  = s2_ld ? &s1_zero_q : out_zero_q;
    out_norm_d  = s2_ld ? s1_data_q << sel_cnt : out_norm_q;
    out_tag_d   = s2_ld ? s1_tag_q : out_tag_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_tag_q    <= '0;
      s1_cnt_q    <= '0;
      s1_zero_q   <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_zero_q  <= 1'b0;
      out_norm_q  <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_tag_q    <= s1_tag_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_zero_q   <= s1_zero_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
      out_norm_q  <= out_norm_d;
      out_tag_q   <= out_tag_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;
  assign out_norm  = out_norm_q;
  assign out_tag   = out_tag_q;
endmodule
